rr_handshake_arbiter: RTL and testbench
=======================================

// Module: rr_handshake_arbiter
// PURPOSE
//  Shares one fully-registered valid/ready output stage between NUM_SRC requesters.
//  Each source is granted in round-robin order, one burst at a time (src_last ends a burst).
//  Accepted beats pass through a 2-entry ping-pong output buffer tagged with source id.
//  Sits in front of any downstream valid/ready consumer needing a single ordered stream.
// PARAMETERS
//  WIDTH    8  data width per beat
//  NUM_SRC  4  number of requesters, >=2, need not be a power of 2
//  IDW      derived localparam = max(1, clog2(NUM_SRC)); width of source id
// PORTS
//  clk          in   1              clock, all state on rising edge
//  s_rst        in   1              synchronous reset, active-high
//  src_valid    in   NUM_SRC        per-source beat valid
//  src_data     in   NUM_SRC*WIDTH  per-source data, source i at [i*WIDTH +: WIDTH]
//  src_last     in   NUM_SRC        per-source last beat of burst
//  src_ready    out  NUM_SRC        per-source accept; at most one bit high per cycle
//  dst_valid    out  1              output beat valid
//  dst_data     out  WIDTH          output data
//  dst_last     out  1              output last flag
//  dst_id       out  IDW            source index of output beat
//  dst_ready    in   1              downstream accept
//  busy         out  1              burst locked or buffer non-empty
// BEHAVIOUR
//  Reset: clock clk; reset s_rst, synchronous, active-high. While s_rst is high: state=ARB,
//   rr_ptr=0, both buffer entries empty, wr/rd pointers=0, dst_valid=0, dst_data=0,
//   dst_last=0, dst_id=0, busy=0. src_ready is forced to all-0 during reset.
//  Reset mid-operation: all buffered beats are discarded; no partial burst state survives.
//  Buffer: 2 entries of {id,last,data}; space = ~(full0 & full1).
//   Push to entry wr_ptr, then toggle wr_ptr. Pop from entry rd_ptr when dst_valid&dst_ready,
//   then toggle rd_ptr. dst_* = entry[rd_ptr]; dst_valid = full[rd_ptr].
//   When both entries are full, there is no push even if a pop occurs in the same cycle:
//   src_ready depends only on registered state plus src_valid.
//   Push and pop in the same cycle with one entry full are both performed.
//  Latency: a beat accepted in cycle N is on dst_* in cycle N+1 if the buffer was empty.
//   Sustained throughput is 1 beat/cycle with dst_ready=1.
//  Winner (ARB): first i with src_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//   There is no winner if src_valid==0.
//  Grant: g = lock_id in LOCK, winner in ARB. src_ready[g] = space & ~s_rst.
//   All other src_ready bits are 0.
//   In ARB with no winner, all src_ready bits are 0.
//  accept = src_valid[g] & src_ready[g]; the pushed beat carries id=g.
//  FSM:
//   ARB -> LOCK: accept & ~src_last[g]; lock_id <= g.
//   ARB -> ARB: accept & src_last[g] (single-beat burst), or no accept.
//   LOCK -> ARB: accept & src_last[lock_id].
//   LOCK -> LOCK otherwise. Stays locked even if src_valid[lock_id] drops; other sources stall.
//  rr_ptr <= (g==NUM_SRC-1) ? 0 : g+1 on every accept with src_last[g]=1. Unchanged otherwise.
//  Source obligation: src_data, src_last, src_valid are held stable while valid & ~ready.
//   The block does not check this.
//  busy = (state==LOCK) | full0 | full1, registered-derived.
// TESTING
//  Reset: s_rst=1 for 3 cycles with src_valid=4'hF -> src_ready=0, dst_valid=0.
//   First cycle after release -> src_ready=4'b0001.
//  Round-robin: all sources valid, last=1, dst_ready=1 -> dst_id=0,1,2,3,0,1,...,
//   one beat/cycle, first dst_valid 1 cycle after first accept.
//  Burst lock: src1 sends 3 beats (last on 3rd) while src2 valid -> dst_id 1,1,1,2.
//   src1 valid low for 2 cycles mid-burst -> src_ready all 0, src2 not granted.
//  Backpressure: dst_ready=0, src0 streams A0..A5 -> exactly A0,A1 accepted, src_ready=0.
//   Then dst_ready=1 -> A0..A5 out in order, no loss or duplication.
//  Reset mid-burst: s_rst pulse in LOCK with 2 entries full -> next cycle dst_valid=0,
//   busy=0, rr_ptr=0, and the next grant goes to the lowest valid index.
//  Wrap, NUM_SRC=3: src2 single-beat then src0 and src2 valid -> next grant src0,
//   dst_id sequence 2,0,2.

Source files
------------

// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter
//   Shares one registered valid/ready output stage between NUM_SRC requesters.
//   Sources are granted round-robin, one burst at a time (src_last closes a
//   burst). Accepted beats go through a 2-entry ping-pong buffer tagged with
//   the source index, so the downstream sees one ordered stream.
//
// Ports
//   clk, s_rst            clock, synchronous active-high reset
//   src_valid/_data/_last per-source beat (source i data at [i*WIDTH +: WIDTH])
//   src_ready             per-source accept, at most one bit high
//   dst_valid/_data/_last output beat, fully registered
//   dst_id                source index of the output beat
//   dst_ready             downstream accept
//   busy                  burst locked or buffer non-empty
//
// FSM states
//   state | meaning
//   ARB   | no burst in progress; grant the round-robin winner
//   LOCK  | mid-burst; only lock_id may be granted until its last beat
module rr_handshake_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_SRC = 4,
  localparam int IDW    = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     s_rst,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_last,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     dst_valid,
  output logic [WIDTH-1:0]         dst_data,
  output logic                     dst_last,
  output logic [IDW-1:0]           dst_id,
  input  logic                     dst_ready,
  output logic                     busy
);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]       full_q, full_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] buf_data_q [2];
  logic [1:0]       buf_last_q;
  logic [IDW-1:0]   buf_id_q [2];

  logic             space;
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic             accept;
  logic             acc_last;
  logic [WIDTH-1:0] acc_data;
  logic             pop;
  int               idx;

  // Round-robin search starting at rr_ptr; NUM_SRC need not be a power of 2,
  // so the wrap is an explicit compare rather than pointer overflow.
  always_comb begin : winner
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!win_found && (i == idx) && src_valid[i]) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
  end

  // src_ready looks only at registered state and src_valid: a pop in the same
  // cycle never frees space for a push when both entries are full.
  always_comb begin : grant
    space     = ~(full_q[0] & full_q[1]);
    grant_vld = (state_q == LOCK) | win_found;
    grant_id  = (state_q == LOCK) ? lock_id_q : win_id;
    src_ready = '0;
    accept    = 1'b0;
    acc_last  = 1'b0;
    acc_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_vld && (grant_id == IDW'(i)) && space && !s_rst) src_ready[i] = 1'b1;
      if (src_ready[i]) begin
        accept   = src_valid[i];
        acc_last = src_last[i];
        acc_data = src_data[i*WIDTH +: WIDTH];
      end
    end
    pop = full_q[rd_ptr_q] & dst_ready;
  end

  always_comb begin : next_state
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    full_d    = full_q;
    if (pop) full_d[rd_ptr_q] = 1'b0;
    if (accept) begin
      full_d[wr_ptr_q] = 1'b1;
      if (acc_last) begin
        state_d  = ARB;
        rr_ptr_d = (int'(grant_id) == NUM_SRC - 1) ? '0 : grant_id + IDW'(1);
      end else if (state_q == ARB) begin
        state_d   = LOCK;
        lock_id_d = grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state_q       <= ARB;
      lock_id_q     <= '0;
      rr_ptr_q      <= '0;
      full_q        <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      buf_id_q[0]   <= '0;
      buf_id_q[1]   <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      full_q    <= full_d;
      if (accept) begin
        buf_data_q[wr_ptr_q] <= acc_data;
        buf_last_q[wr_ptr_q] <= acc_last;
        buf_id_q[wr_ptr_q]   <= grant_id;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign dst_valid = full_q[rd_ptr_q];
  assign dst_data  = buf_data_q[rd_ptr_q];
  assign dst_last  = buf_last_q[rd_ptr_q];
  assign dst_id    = buf_id_q[rd_ptr_q];
  assign busy      = (state_q == LOCK) | full_q[0] | full_q[1];

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
module tb_rr_handshake_arbiter;

  logic        clk = 1'b0;
  logic        s_rst;
  logic [3:0]  src_valid, src_last, src_ready;
  logic [31:0] src_data;
  logic        dst_valid, dst_last, dst_ready, busy;
  logic [7:0]  dst_data;
  logic [1:0]  dst_id;

  logic        s3_rst;
  logic [2:0]  s3_valid, s3_last, s3_ready;
  logic [23:0] s3_data;
  logic        s3_dv, s3_dl, s3_dr, s3_busy;
  logic [7:0]  s3_dd;
  logic [1:0]  s3_did;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_handshake_arbiter #(.WIDTH(8), .NUM_SRC(4)) dut (
    .clk(clk), .s_rst(s_rst), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .dst_valid(dst_valid),
    .dst_data(dst_data), .dst_last(dst_last), .dst_id(dst_id),
    .dst_ready(dst_ready), .busy(busy));

  rr_handshake_arbiter #(.WIDTH(8), .NUM_SRC(3)) dut3 (
    .clk(clk), .s_rst(s3_rst), .src_valid(s3_valid), .src_data(s3_data),
    .src_last(s3_last), .src_ready(s3_ready), .dst_valid(s3_dv),
    .dst_data(s3_dd), .dst_last(s3_dl), .dst_id(s3_did),
    .dst_ready(s3_dr), .busy(s3_busy));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset4();
    @(negedge clk);
    s_rst = 1'b1; src_valid = '0; src_last = '0; dst_ready = 1'b0;
    @(negedge clk);
    s_rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       dr;
    logic [3:0] e_rdy;
    logic       e_dv;
    logic [1:0] e_id;
    logic       e_busy;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic       last;
    logic [7:0] data;
  } beat_t;

  vec_t       tbl [18];
  logic [7:0] got [$];
  beat_t      mq [$];
  logic [3:0] s_v, s_l;
  logic [7:0] s_d [4];
  logic [3:0] exp_rdy;
  int         k, g, last_acc;
  bit         has, acc, m_locked, rnd_rst;
  int         m_lock_id, m_rr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    s_rst = 1'b1; src_valid = '0; src_last = '0; dst_ready = 1'b0; src_data = '0;
    s3_rst = 1'b1; s3_valid = '0; s3_last = '0; s3_dr = 1'b0;
    s3_data = {8'hC2, 8'hC1, 8'hC0};

    //            rst   v      l      dr    rdy    dv    id     busy
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 4'h6, 4'h4, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 4'h6, 4'h4, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 4'h4, 4'h4, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 4'h4, 4'h4, 1'b1, 4'h2, 1'b0, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 4'h6, 4'h6, 1'b1, 4'h2, 1'b0, 2'd0, 1'b1};
    tbl[15] = '{1'b0, 4'h4, 4'h4, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1};
    tbl[17] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0};

    // one reset edge so registers are defined before the table starts
    @(negedge clk);
    src_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};

    // table: reset, round-robin, burst lock with mid-burst stall
    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      s_rst = tbl[r].rst; src_valid = tbl[r].v; src_last = tbl[r].l; dst_ready = tbl[r].dr;
      #1;
      check($sformatf("tbl%0d src_ready", r), 32'(src_ready), 32'(tbl[r].e_rdy));
      check($sformatf("tbl%0d dst_valid", r), 32'(dst_valid), 32'(tbl[r].e_dv));
      check($sformatf("tbl%0d busy", r), 32'(busy), 32'(tbl[r].e_busy));
      if (tbl[r].e_dv) begin
        check($sformatf("tbl%0d dst_id", r), 32'(dst_id), 32'(tbl[r].e_id));
        check($sformatf("tbl%0d dst_data", r), 32'(dst_data), 32'(8'hD0 + 8'(tbl[r].e_id)));
      end
    end

    // backpressure: only two beats fit while dst_ready is low
    reset4();
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      dst_ready = 1'b0; src_valid = (k < 6) ? 4'b0001 : 4'b0000; src_last = 4'b0001;
      src_data[7:0] = 8'(8'hA0 + k);
      #1;
      if (src_ready[0] && src_valid[0]) k++;
    end
    check("bp accepted", 32'(k), 32'd2);
    check("bp src_ready", 32'(src_ready), 32'd0);
    check("bp busy", 32'(busy), 32'd1);
    check("bp head", 32'(dst_data), 32'hA0);
    got.delete();
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge clk);
      dst_ready = 1'b1; src_valid = (k < 6) ? 4'b0001 : 4'b0000;
      src_data[7:0] = 8'(8'hA0 + k);
      #1;
      if (dst_valid) got.push_back(dst_data);
      if (src_ready[0] && src_valid[0]) k++;
    end
    check("bp out count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("bp out%0d", i), 32'(got[i]), 32'(8'hA0 + i));
    @(negedge clk);
    src_valid = '0;
    #1;
    check("bp drained", 32'(dst_valid), 32'd0);

    // reset while locked with both entries full
    reset4();
    src_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    @(negedge clk);
    dst_ready = 1'b1; src_valid = 4'b0100; src_last = 4'b0100;
    #1; check("mr first grant", 32'(src_ready), 32'h4);
    @(negedge clk);
    dst_ready = 1'b0; src_valid = 4'b0010; src_last = 4'b0000;
    #1; check("mr lock grant", 32'(src_ready), 32'h2);
    @(negedge clk);
    #1;
    check("mr full ready", 32'(src_ready), 32'h0);
    check("mr full busy", 32'(busy), 32'd1);
    check("mr full valid", 32'(dst_valid), 32'd1);
    @(negedge clk);
    s_rst = 1'b1;
    #1; check("mr rst ready", 32'(src_ready), 32'h0);
    @(negedge clk);
    s_rst = 1'b0; src_valid = 4'b1100; src_last = 4'b1100; dst_ready = 1'b1;
    #1;
    check("mr post dst_valid", 32'(dst_valid), 32'd0);
    check("mr post busy", 32'(busy), 32'd0);
    check("mr post grant", 32'(src_ready), 32'h4);
    @(negedge clk);
    src_valid = '0;
    #1;
    check("mr post out valid", 32'(dst_valid), 32'd1);
    check("mr post out id", 32'(dst_id), 32'd2);

    // NUM_SRC=3 wrap
    @(negedge clk);
    s3_rst = 1'b0; s3_valid = 3'b100; s3_last = 3'b111; s3_dr = 1'b1;
    #1;
    check("w3 grant2", 32'(s3_ready), 32'h4);
    check("w3 empty", 32'(s3_dv), 32'd0);
    @(negedge clk);
    s3_valid = 3'b101;
    #1;
    check("w3 wrap grant0", 32'(s3_ready), 32'h1);
    check("w3 out id2", 32'(s3_did), 32'd2);
    check("w3 out data2", 32'(s3_dd), 32'hC2);
    @(negedge clk);
    s3_valid = 3'b100;
    #1;
    check("w3 grant2 again", 32'(s3_ready), 32'h4);
    check("w3 out id0", 32'(s3_did), 32'd0);
    @(negedge clk);
    s3_valid = 3'b000;
    #1;
    check("w3 out valid", 32'(s3_dv), 32'd1);
    check("w3 out id2b", 32'(s3_did), 32'd2);

    // randomized run against a queue-based reference
    reset4();
    mq.delete(); m_locked = 0; m_lock_id = 0; m_rr = 0; last_acc = -1;
    s_v = '0; s_l = '0;
    for (int i = 0; i < 4; i++) s_d[i] = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (last_acc >= 0) begin
        s_v[last_acc] = ($urandom_range(0, 9) < 7);
        s_d[last_acc] = 8'($urandom);
        s_l[last_acc] = ($urandom_range(0, 2) == 0);
      end
      for (int i = 0; i < 4; i++) begin
        if (!s_v[i] && $urandom_range(0, 9) < 3) begin
          s_v[i] = 1'b1; s_d[i] = 8'($urandom); s_l[i] = ($urandom_range(0, 2) == 0);
        end
      end
      rnd_rst = ($urandom_range(0, 299) == 0);
      s_rst = rnd_rst;
      dst_ready = ($urandom_range(0, 3) != 0);
      src_valid = s_v; src_last = s_l;
      for (int i = 0; i < 4; i++) src_data[i*8 +: 8] = s_d[i];
      #1;
      has = 0; g = 0;
      if (m_locked) begin
        has = 1; g = m_lock_id;
      end else begin
        for (int j = 0; j < 4; j++)
          if (!has && s_v[(m_rr + j) % 4]) begin has = 1; g = (m_rr + j) % 4; end
      end
      exp_rdy = (has && mq.size() < 2 && !rnd_rst) ? 4'(1 << g) : 4'h0;
      check("rnd src_ready", 32'(src_ready), 32'(exp_rdy));
      check("rnd dst_valid", 32'(dst_valid), 32'(mq.size() > 0));
      check("rnd busy", 32'(busy), 32'(m_locked || mq.size() > 0));
      if (mq.size() > 0) begin
        check("rnd dst_id", 32'(dst_id), 32'(mq[0].id));
        check("rnd dst_data", 32'(dst_data), 32'(mq[0].data));
        check("rnd dst_last", 32'(dst_last), 32'(mq[0].last));
      end
      if (rnd_rst) begin
        mq.delete(); m_locked = 0; m_rr = 0; last_acc = -1;
      end else begin
        acc = has && exp_rdy[g] && s_v[g];
        if (mq.size() > 0 && dst_ready) void'(mq.pop_front());
        if (acc) begin
          mq.push_back('{2'(g), s_l[g], s_d[g]});
          if (s_l[g]) begin
            m_locked = 0; m_rr = (g + 1) % 4;
          end else if (!m_locked) begin
            m_locked = 1; m_lock_id = g;
          end
        end
        last_acc = acc ? g : -1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
